// File: rtl/uno_pkg.sv
// Shared constants for the card-hand block: empty-slot code, default hand size,
// screen geometry of the hand row, and the removal FSM state encoding.
// Imported by hand_manager and hand_hit_test.
package uno_pkg;

  localparam logic [5:0] NO_CARD       = 6'h3F;
  localparam int         MAX_CARDS_DEF = 8;

  localparam int HAND_X0_DEF = 40;
  localparam int HAND_Y0_DEF = 368;
  localparam int PITCH_DEF   = 72;
  localparam int CARD_W_DEF  = 64;
  localparam int CARD_H_DEF  = 96;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } hand_state_t;

  // Left edge of slot k, in 10-bit screen coordinates.
  function automatic logic [9:0] slot_x(input int k, input int x0, input int pitch);
    return 10'(x0 + k * pitch);
  endfunction

endpackage

// File: rtl/hand_hit_test.sv
// Purpose: combinational test of which occupied hand slot contains the pixel.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of x_cnt, y_cnt and count.
// Ports: x_cnt/y_cnt pixel position, count cards held; hit = some slot
//        contains the pixel, index = lowest such slot.
module hand_hit_test
  import uno_pkg::*;
#(
  parameter int MAX_CARDS = MAX_CARDS_DEF,
  parameter int HAND_X0   = HAND_X0_DEF,
  parameter int HAND_Y0   = HAND_Y0_DEF,
  parameter int PITCH     = PITCH_DEF,
  parameter int CARD_W    = CARD_W_DEF,
  parameter int CARD_H    = CARD_H_DEF
) (
  input  logic [9:0] x_cnt,
  input  logic [9:0] y_cnt,
  input  logic [3:0] count,
  output logic       hit,
  output logic [2:0] index
);

  logic       y_in;
  logic [9:0] x_lo;

  always_comb begin
    y_in  = (y_cnt >= 10'(HAND_Y0)) && (y_cnt < 10'(HAND_Y0 + CARD_H));
    hit   = 1'b0;
    index = 3'd0;
    x_lo  = 10'd0;
    // Scan from the top slot down so the lowest matching slot is the last
    // one written and therefore wins.
    for (int k = MAX_CARDS - 1; k >= 0; k--) begin
      x_lo = slot_x(k, HAND_X0, PITCH);
      if (y_in && (4'(k) < count) && (x_cnt >= x_lo) && (x_cnt < x_lo + 10'(CARD_W))) begin
        hit   = 1'b1;
        index = 3'(k);
      end
    end
  end

endmodule

// File: rtl/hand_manager.sv
// Purpose: holds a hand of up to MAX_CARDS card codes, appends/removes cards
//          (removal compacts the hand one slot per cycle) and drives the hit
//          test that tells the card renderer which card sits under the pixel.
// Latency: add 1 cycle; remove count-rm_idx shift cycles + 1 done cycle;
//          display outputs 1 cycle after x_cnt/y_cnt.
// Backpressure: add_ready/rm_ready low while a removal is in progress; add
//          also held off when full or when a remove is requested.
// Ports: clk/rst (sync, active-high); add_* append handshake; rm_* remove
//        handshake with rm_card/rm_done/rm_err results; x_cnt/y_cnt pixel in,
//        card/x_pin/y_pin/card_hit/x_cnt_o/y_cnt_o aligned display out;
//        count/full/empty hand status.
module hand_manager
  import uno_pkg::*;
#(
  parameter int MAX_CARDS = MAX_CARDS_DEF,
  parameter int HAND_X0   = HAND_X0_DEF,
  parameter int HAND_Y0   = HAND_Y0_DEF,
  parameter int PITCH     = PITCH_DEF,
  parameter int CARD_W    = CARD_W_DEF,
  parameter int CARD_H    = CARD_H_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add_valid,
  input  logic [5:0] add_card,
  output logic       add_ready,
  input  logic       rm_valid,
  input  logic [2:0] rm_idx,
  output logic       rm_ready,
  output logic [5:0] rm_card,
  output logic       rm_done,
  output logic       rm_err,
  input  logic [9:0] x_cnt,
  input  logic [9:0] y_cnt,
  output logic [5:0] card,
  output logic [9:0] x_pin,
  output logic [9:0] y_pin,
  output logic [9:0] x_cnt_o,
  output logic [9:0] y_cnt_o,
  output logic       card_hit,
  output logic [3:0] count,
  output logic       full,
  output logic       empty
);

  hand_state_t state;
  logic [5:0]  slots [MAX_CARDS];
  logic [2:0]  ptr;
  logic [2:0]  ptr_nxt;
  logic        hit;
  logic [2:0]  hit_idx;

  assign full      = (count == 4'(MAX_CARDS));
  assign empty     = (count == 4'd0);
  assign add_ready = (state == ST_IDLE) && !full && !rm_valid;
  assign rm_ready  = (state == ST_IDLE) && !empty;
  assign rm_done   = (state == ST_DONE);
  assign ptr_nxt   = ptr + 3'd1;

  // Hand state and removal FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= 4'd0;
      ptr     <= 3'd0;
      rm_card <= NO_CARD;
      rm_err  <= 1'b0;
      for (int i = 0; i < MAX_CARDS; i++) slots[i] <= NO_CARD;
    end else begin
      rm_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rm_valid && rm_ready) begin
            if ({1'b0, rm_idx} >= count) begin
              rm_err <= 1'b1;
            end else begin
              rm_card <= slots[rm_idx];
              ptr     <= rm_idx;
              state   <= ST_SHIFT;
            end
          end else if (add_valid && add_ready) begin
            slots[count[2:0]] <= add_card;
            count             <= count + 4'd1;
          end
        end
        ST_SHIFT: begin
          // Pull each later card down one slot; the old last slot empties.
          if ({1'b0, ptr} == count - 4'd1) begin
            slots[ptr] <= NO_CARD;
            count      <= count - 4'd1;
            state      <= ST_DONE;
          end else begin
            slots[ptr] <= slots[ptr_nxt];
            ptr        <= ptr_nxt;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  hand_hit_test #(
    .MAX_CARDS(MAX_CARDS),
    .HAND_X0  (HAND_X0),
    .HAND_Y0  (HAND_Y0),
    .PITCH    (PITCH),
    .CARD_W   (CARD_W),
    .CARD_H   (CARD_H)
  ) u_hit (
    .x_cnt(x_cnt),
    .y_cnt(y_cnt),
    .count(count),
    .hit  (hit),
    .index(hit_idx)
  );

  // Display path reads the live slots, so mid-shift duplicates may show.
  always_ff @(posedge clk) begin
    if (rst) begin
      card_hit <= 1'b0;
      card     <= NO_CARD;
      x_pin    <= 10'd0;
      y_pin    <= 10'd0;
      x_cnt_o  <= 10'd0;
      y_cnt_o  <= 10'd0;
    end else begin
      x_cnt_o  <= x_cnt;
      y_cnt_o  <= y_cnt;
      card_hit <= hit;
      if (hit) begin
        card  <= slots[hit_idx];
        x_pin <= slot_x(int'(hit_idx), HAND_X0, PITCH);
        y_pin <= 10'(HAND_Y0);
      end else begin
        card  <= NO_CARD;
        x_pin <= 10'd0;
        y_pin <= 10'd0;
      end
    end
  end

endmodule

// File: tb/tb_hand_manager.sv
// Bench for hand_manager: directed scenarios plus randomized add/remove and
// pixel traffic, compared against a queue-based model of the hand.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_hand_manager;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       add_valid = 1'b0;
  logic [5:0] add_card = 6'd0;
  logic       add_ready;
  logic       rm_valid = 1'b0;
  logic [2:0] rm_idx = 3'd0;
  logic       rm_ready;
  logic [5:0] rm_card;
  logic       rm_done;
  logic       rm_err;
  logic [9:0] x_cnt = 10'd0;
  logic [9:0] y_cnt = 10'd0;
  logic [5:0] card;
  logic [9:0] x_pin, y_pin, x_cnt_o, y_cnt_o;
  logic       card_hit;
  logic [3:0] count;
  logic       full, empty;

  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] model_q[$];

  always #5 clk = ~clk;

  hand_manager dut (
    .clk(clk), .rst(rst),
    .add_valid(add_valid), .add_card(add_card), .add_ready(add_ready),
    .rm_valid(rm_valid), .rm_idx(rm_idx), .rm_ready(rm_ready),
    .rm_card(rm_card), .rm_done(rm_done), .rm_err(rm_err),
    .x_cnt(x_cnt), .y_cnt(y_cnt),
    .card(card), .x_pin(x_pin), .y_pin(y_pin),
    .x_cnt_o(x_cnt_o), .y_cnt_o(y_cnt_o), .card_hit(card_hit),
    .count(count), .full(full), .empty(empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; add_valid = 1'b0; rm_valid = 1'b0;
    tick; tick;
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic do_add(input logic [5:0] c);
    int t = 0;
    while (!add_ready && t < 20) begin tick; t++; end
    if (!add_ready) begin
      n_checks++;
      $display("FAIL add_timeout add_ready=%0b required 1", add_ready);
    end else begin
      add_valid = 1'b1; add_card = c;
      tick;
      add_valid = 1'b0;
      model_q.push_back(c);
    end
  endtask

  // Issue one remove and watch the following 12 cycles.
  task automatic do_remove(input logic [2:0] idx, output int done_cyc,
                           output int pulses, output int errs);
    done_cyc = 0; pulses = 0; errs = 0;
    rm_valid = 1'b1; rm_idx = idx;
    tick;
    rm_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (rm_done) begin pulses++; if (done_cyc == 0) done_cyc = c; end
      if (rm_err) errs++;
      tick;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (count !== 4'd0) $display("FAIL rst_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_flags empty=%0b full=%0b exp 1/0", empty, full); else n_pass++;
    n_checks++; if (add_ready !== 1'b1 || rm_ready !== 1'b0) $display("FAIL rst_ready add=%0b rm=%0b exp 1/0", add_ready, rm_ready); else n_pass++;
    n_checks++; if (rm_done !== 1'b0 || rm_err !== 1'b0) $display("FAIL rst_pulses done=%0b err=%0b exp 0/0", rm_done, rm_err); else n_pass++;
    n_checks++; if (rm_card !== 6'h3F) $display("FAIL rst_rm_card got=%h exp=3f", rm_card); else n_pass++;
    n_checks++;
    if (card_hit !== 1'b0 || card !== 6'h3F || x_pin !== 10'd0 || y_pin !== 10'd0 || x_cnt_o !== 10'd0 || y_cnt_o !== 10'd0)
      $display("FAIL rst_display hit=%0b card=%h xp=%0d yp=%0d xo=%0d yo=%0d exp 0/3f/0/0/0/0", card_hit, card, x_pin, y_pin, x_cnt_o, y_cnt_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (dut.slots[i] !== 6'h3F) $display("FAIL rst_slot%0d got=%h exp=3f", i, dut.slots[i]); else n_pass++;
    end
  endtask

  task automatic test_add;
    do_reset;
    do_add(6'h05); do_add(6'h12); do_add(6'h21);
    n_checks++; if (count !== 4'd3) $display("FAIL add_count got=%0d exp=3", count); else n_pass++;
    n_checks++; if (add_ready !== 1'b1) $display("FAIL add_ready got=%0b exp=1", add_ready); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      logic [5:0] e;
      e = (i < model_q.size()) ? model_q[i] : 6'h3F;
      n_checks++; if (dut.slots[i] !== e) $display("FAIL add_slot%0d got=%h exp=%h", i, dut.slots[i], e); else n_pass++;
    end
  endtask

  task automatic test_remove;
    int dc, pc, ec;
    // continues from test_add: hand {05,12,21}
    do_remove(3'd0, dc, pc, ec);
    n_checks++; if (rm_card !== 6'h05) $display("FAIL rm_card got=%h exp=05", rm_card); else n_pass++;
    n_checks++; if (dc !== 4 || pc !== 1) $display("FAIL rm_done_timing cycle=%0d pulses=%0d exp 4/1", dc, pc); else n_pass++;
    n_checks++; if (ec !== 0) $display("FAIL rm_spurious_err got=%0d exp=0", ec); else n_pass++;
    model_q.delete(0);
    n_checks++; if (count !== 4'd2) $display("FAIL rm_count got=%0d exp=2", count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      logic [5:0] e;
      e = (i < model_q.size()) ? model_q[i] : 6'h3F;
      n_checks++; if (dut.slots[i] !== e) $display("FAIL rm_slot%0d got=%h exp=%h", i, dut.slots[i], e); else n_pass++;
    end
  endtask

  task automatic test_rm_error;
    int dc, pc, ec;
    // hand of 2 from test_remove
    do_remove(3'd5, dc, pc, ec);
    n_checks++; if (ec !== 1) $display("FAIL err_pulse count=%0d exp=1", ec); else n_pass++;
    n_checks++; if (pc !== 0) $display("FAIL err_no_done pulses=%0d exp=0", pc); else n_pass++;
    n_checks++; if (count !== 4'd2 || dut.slots[0] !== 6'h12 || dut.slots[1] !== 6'h21)
      $display("FAIL err_unchanged count=%0d s0=%h s1=%h exp 2/12/21", count, dut.slots[0], dut.slots[1]);
    else n_pass++;
  endtask

  task automatic test_full;
    int dc, pc, ec;
    do_reset;
    for (int i = 0; i < 8; i++) do_add(6'(i + 8));
    n_checks++; if (full !== 1'b1 || add_ready !== 1'b0 || count !== 4'd8)
      $display("FAIL full_flags full=%0b add_ready=%0b count=%0d exp 1/0/8", full, add_ready, count);
    else n_pass++;
    add_valid = 1'b1; add_card = 6'h2A; tick; tick; add_valid = 1'b0;
    n_checks++; if (count !== 4'd8 || dut.slots[7] !== 6'd15) $display("FAIL full_ignore count=%0d s7=%h exp 8/0f", count, dut.slots[7]); else n_pass++;
    do_remove(3'd7, dc, pc, ec);
    model_q.delete(7);
    // simultaneous add and remove with room for the add: only the remove goes
    add_valid = 1'b1; add_card = 6'h33; rm_valid = 1'b1; rm_idx = 3'd2;
    #1;
    n_checks++; if (add_ready !== 1'b0) $display("FAIL prio_add_ready got=%0b exp=0", add_ready); else n_pass++;
    tick;
    add_valid = 1'b0; rm_valid = 1'b0;
    for (int c = 0; c < 12; c++) tick;
    model_q.delete(2);
    n_checks++; if (count !== 4'(model_q.size())) $display("FAIL prio_count got=%0d exp=%0d", count, model_q.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      logic [5:0] e;
      e = (i < model_q.size()) ? model_q[i] : 6'h3F;
      n_checks++; if (dut.slots[i] !== e) $display("FAIL prio_slot%0d got=%h exp=%h", i, dut.slots[i], e); else n_pass++;
    end
  endtask

  task automatic test_display;
    do_reset;
    do_add(6'h05); do_add(6'h12);
    x_cnt = 10'd112; y_cnt = 10'd400; tick;
    n_checks++;
    if (card_hit !== 1'b1 || card !== 6'h12 || x_pin !== 10'd112 || y_pin !== 10'd368 || x_cnt_o !== 10'd112 || y_cnt_o !== 10'd400)
      $display("FAIL disp_hit hit=%0b card=%h xp=%0d yp=%0d xo=%0d yo=%0d exp 1/12/112/368/112/400", card_hit, card, x_pin, y_pin, x_cnt_o, y_cnt_o);
    else n_pass++;
    x_cnt = 10'd104; tick;
    n_checks++; if (card_hit !== 1'b0 || card !== 6'h3F || x_pin !== 10'd0)
      $display("FAIL disp_gap hit=%0b card=%h xp=%0d exp 0/3f/0", card_hit, card, x_pin);
    else n_pass++;
  endtask

  // Random pixels against the current hand; slot = (x-x0)/pitch.
  task automatic test_random_display;
    for (int n = 0; n < 40; n++) begin
      int x, y, k;
      logic eh; logic [5:0] ec; logic [9:0] ex, ey;
      x = $urandom_range(0, 699); y = $urandom_range(340, 490);
      x_cnt = 10'(x); y_cnt = 10'(y);
      tick;
      eh = 0; ec = 6'h3F; ex = 0; ey = 0;
      if (y >= 368 && y < 464 && x >= 40) begin
        k = (x - 40) / 72;
        if ((x - 40) % 72 < 64 && k < model_q.size()) begin
          eh = 1; ec = model_q[k]; ex = 10'(40 + 72 * k); ey = 10'd368;
        end
      end
      n_checks++;
      if (card_hit !== eh || card !== ec || x_pin !== ex || y_pin !== ey || x_cnt_o !== 10'(x))
        $display("FAIL rnd_disp (%0d,%0d) hit=%0b card=%h xp=%0d yp=%0d exp %0b/%h/%0d/%0d", x, y, card_hit, card, x_pin, y_pin, eh, ec, ex, ey);
      else n_pass++;
    end
  endtask

  task automatic test_random_ops;
    do_reset;
    for (int n = 0; n < 40; n++) begin
      if (model_q.size() == 0 || (model_q.size() < 8 && $urandom_range(0, 1) == 1)) begin
        do_add(6'($urandom_range(0, 62)));
      end else begin
        int dc, pc, ec, idx, sz;
        logic [5:0] ecard;
        idx = $urandom_range(0, 7); sz = model_q.size();
        ecard = rm_card;
        do_remove(3'(idx), dc, pc, ec);
        if (idx < sz) begin
          ecard = model_q[idx];
          model_q.delete(idx);
          n_checks++; if (dc !== sz - idx + 1 || pc !== 1 || ec !== 0)
            $display("FAIL rnd_rm idx=%0d done_cycle=%0d pulses=%0d err=%0d exp %0d/1/0", idx, dc, pc, ec, sz - idx + 1);
          else n_pass++;
        end else begin
          n_checks++; if (ec !== 1 || pc !== 0) $display("FAIL rnd_rm_err idx=%0d err=%0d done=%0d exp 1/0", idx, ec, pc); else n_pass++;
        end
        n_checks++; if (rm_card !== ecard) $display("FAIL rnd_rm_card got=%h exp=%h", rm_card, ecard); else n_pass++;
      end
      n_checks++; if (count !== 4'(model_q.size())) $display("FAIL rnd_count got=%0d exp=%0d", count, model_q.size()); else n_pass++;
      for (int i = 0; i < 8; i++) begin
        logic [5:0] e;
        e = (i < model_q.size()) ? model_q[i] : 6'h3F;
        n_checks++; if (dut.slots[i] !== e) $display("FAIL rnd_slot%0d got=%h exp=%h", i, dut.slots[i], e); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    int pulses = 0;
    do_reset;
    for (int i = 0; i < 4; i++) do_add(6'(i + 1));
    rm_valid = 1'b1; rm_idx = 3'd0; tick; rm_valid = 1'b0;
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    model_q.delete();
    n_checks++; if (count !== 4'd0) $display("FAIL mid_rst_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (add_ready !== 1'b1 || rm_done !== 1'b0) $display("FAIL mid_rst_idle add_ready=%0b rm_done=%0b exp 1/0", add_ready, rm_done); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (dut.slots[i] !== 6'h3F) $display("FAIL mid_rst_slot%0d got=%h exp=3f", i, dut.slots[i]); else n_pass++;
    end
    for (int c = 0; c < 6; c++) begin if (rm_done) pulses++; tick; end
    n_checks++; if (pulses !== 0) $display("FAIL mid_rst_done pulses=%0d exp=0", pulses); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_remove;
    test_rm_error;
    test_full;
    test_display;
    test_random_ops;
    test_random_display;
    test_reset_mid_shift;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
